// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, state encodings and helpers for the burst-capable system controller.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [7:0] CMD_BURST   = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_ISSUE,
        RD_WAIT,
        OPA,
        OPB,
        ALU_FUN_S,
        ALU_WAIT,
        ALU_PUSH_HI,
        BR_ADDR,
        BR_LEN,
        BR_ISSUE,
        BR_WAIT
    } cmd_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    // States in which an incoming RX word is consumed rather than flagged as overrun.
    function automatic logic is_accepting(input cmd_state_t s);
        return (s inside {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUN_S, BR_ADDR, BR_LEN});
    endfunction

endpackage

// File: rtl/sys_ctrl_burst_resp_fifo.sv
// Response FIFO: synchronous, first-word-fall-through, extra pointer bit separates full from empty.
module resp_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[PW-1:0]] <= push_data;
        end
    end

    // Head word is visible combinationally so the sender can register it on the pop cycle.
    assign pop_data = mem[rd_ptr_reg[PW-1:0]];

endmodule

// File: rtl/sys_ctrl_burst.sv
// System controller: decodes UART command frames, drives register file and ALU, paces responses to TX.
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int DW           = 8,
    parameter int AW           = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [DW-1:0]   RX_P_DATA,
    input  logic            RX_D_VLD,
    input  logic [2*DW-1:0] ALU_OUT,
    input  logic            OUT_Valid,
    input  logic [DW-1:0]   RdData,
    input  logic            RdData_Valid,
    input  logic            TX_OUT_Busy,
    output logic            ALU_EN,
    output logic [3:0]      ALU_FUN,
    output logic            CLK_EN,
    output logic [AW-1:0]   Address,
    output logic            WrEn,
    output logic            RdEn,
    output logic [DW-1:0]   WrData,
    output logic [DW-1:0]   TX_P_DATA,
    output logic            TX_D_VLD,
    output logic            CMD_ERR,
    output logic            RX_OVR
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    cmd_state_t      state_reg;
    tx_state_t       tx_state_reg;

    logic            alu_en_reg;
    logic [3:0]      alu_fun_reg;
    logic            clk_en_reg;
    logic [AW-1:0]   address_reg;
    logic            wr_en_reg;
    logic            rd_en_reg;
    logic [DW-1:0]   wr_data_reg;
    logic            cmd_err_reg;
    logic            rx_ovr_reg;
    logic [AW-1:0]   addr_hold_reg;
    logic [AW-1:0]   burst_addr_reg;
    logic [DW-1:0]   len_reg;
    logic [2*DW-1:0] alu_res_reg;
    logic            lo_pending_reg;

    logic [DW-1:0]   tx_data_reg;
    logic            tx_vld_reg;
    logic [TW-1:0]   timer_reg;

    logic            push_en;
    logic [DW-1:0]   push_data;
    logic            pop_en;
    logic [DW-1:0]   pop_data;
    logic            fifo_full;
    logic            fifo_empty;

    resp_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (CLK),
        .srst      (RST),
        .push      (push_en),
        .push_data (push_data),
        .pop       (pop_en),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Response pushes: read data in either wait state, ALU low half then high half.
    always_comb begin
        push_en   = 1'b0;
        push_data = RdData;
        case (state_reg)
            RD_WAIT, BR_WAIT: begin
                push_en = RdData_Valid;
            end
            ALU_WAIT: begin
                push_en   = OUT_Valid && !fifo_full;
                push_data = ALU_OUT[DW-1:0];
            end
            ALU_PUSH_HI: begin
                push_en   = !fifo_full;
                push_data = lo_pending_reg ? alu_res_reg[DW-1:0] : alu_res_reg[2*DW-1:DW];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            alu_en_reg     <= 1'b0;
            alu_fun_reg    <= '0;
            clk_en_reg     <= 1'b0;
            address_reg    <= '0;
            wr_en_reg      <= 1'b0;
            rd_en_reg      <= 1'b0;
            wr_data_reg    <= '0;
            cmd_err_reg    <= 1'b0;
            rx_ovr_reg     <= 1'b0;
            addr_hold_reg  <= '0;
            burst_addr_reg <= '0;
            len_reg        <= '0;
            alu_res_reg    <= '0;
            lo_pending_reg <= 1'b0;
        end else begin
            alu_en_reg  <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            cmd_err_reg <= 1'b0;
            rx_ovr_reg  <= RX_D_VLD && !is_accepting(state_reg);

            case (state_reg)
                IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA[7:0])
                            CMD_WR:      state_reg <= WR_ADDR;
                            CMD_RD:      state_reg <= RD_ADDR;
                            CMD_ALU_OP:  state_reg <= OPA;
                            CMD_ALU_NOP: state_reg <= ALU_FUN_S;
                            CMD_BURST:   state_reg <= BR_ADDR;
                            default:     cmd_err_reg <= 1'b1;
                        endcase
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_hold_reg <= RX_P_DATA[AW-1:0];
                        state_reg     <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        wr_en_reg   <= 1'b1;
                        address_reg <= addr_hold_reg;
                        wr_data_reg <= RX_P_DATA;
                        state_reg   <= IDLE;
                    end
                end
                RD_ADDR: begin
                    // Issue straight from the address word when there is room to land the reply.
                    if (RX_D_VLD) begin
                        address_reg <= RX_P_DATA[AW-1:0];
                        if (!fifo_full) begin
                            rd_en_reg <= 1'b1;
                            state_reg <= RD_WAIT;
                        end else begin
                            state_reg <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (!fifo_full) begin
                        rd_en_reg <= 1'b1;
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (RdData_Valid) begin
                        state_reg <= IDLE;
                    end
                end
                OPA: begin
                    if (RX_D_VLD) begin
                        wr_en_reg   <= 1'b1;
                        address_reg <= '0;
                        wr_data_reg <= RX_P_DATA;
                        state_reg   <= OPB;
                    end
                end
                OPB: begin
                    if (RX_D_VLD) begin
                        wr_en_reg   <= 1'b1;
                        address_reg <= AW'(1);
                        wr_data_reg <= RX_P_DATA;
                        state_reg   <= ALU_FUN_S;
                    end
                end
                ALU_FUN_S: begin
                    if (RX_D_VLD) begin
                        alu_en_reg  <= 1'b1;
                        alu_fun_reg <= RX_P_DATA[3:0];
                        clk_en_reg  <= 1'b1;
                        state_reg   <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (OUT_Valid) begin
                        clk_en_reg     <= 1'b0;
                        alu_res_reg    <= ALU_OUT;
                        lo_pending_reg <= fifo_full;
                        state_reg      <= ALU_PUSH_HI;
                    end
                end
                ALU_PUSH_HI: begin
                    if (!fifo_full) begin
                        if (lo_pending_reg) begin
                            lo_pending_reg <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                BR_ADDR: begin
                    if (RX_D_VLD) begin
                        burst_addr_reg <= RX_P_DATA[AW-1:0];
                        state_reg      <= BR_LEN;
                    end
                end
                BR_LEN: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == '0) begin
                            cmd_err_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            len_reg   <= RX_P_DATA;
                            state_reg <= BR_ISSUE;
                        end
                    end
                end
                BR_ISSUE: begin
                    if (!fifo_full) begin
                        rd_en_reg   <= 1'b1;
                        address_reg <= burst_addr_reg;
                        state_reg   <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    // Address wraps naturally at AW bits.
                    if (RdData_Valid) begin
                        burst_addr_reg <= burst_addr_reg + 1'b1;
                        len_reg        <= len_reg - 1'b1;
                        state_reg      <= (len_reg == DW'(1)) ? IDLE : BR_ISSUE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pop_en = (tx_state_reg == TX_IDLE) && !fifo_empty && !TX_OUT_Busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_reg <= TX_IDLE;
            tx_data_reg  <= '0;
            tx_vld_reg   <= 1'b0;
            timer_reg    <= '0;
        end else begin
            tx_vld_reg <= 1'b0;
            case (tx_state_reg)
                TX_IDLE: begin
                    if (pop_en) begin
                        tx_data_reg  <= pop_data;
                        tx_vld_reg   <= 1'b1;
                        timer_reg    <= '0;
                        tx_state_reg <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: begin
                    // A transmitter that never acknowledges must not wedge the response path.
                    if (TX_OUT_Busy) begin
                        tx_state_reg <= TX_WAIT_DONE;
                    end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
                        tx_state_reg <= TX_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!TX_OUT_Busy) begin
                        tx_state_reg <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_reg <= TX_IDLE;
                end
            endcase
        end
    end

    assign ALU_EN    = alu_en_reg;
    assign ALU_FUN   = alu_fun_reg;
    assign CLK_EN    = clk_en_reg;
    assign Address   = address_reg;
    assign WrEn      = wr_en_reg;
    assign RdEn      = rd_en_reg;
    assign WrData    = wr_data_reg;
    assign TX_P_DATA = tx_data_reg;
    assign TX_D_VLD  = tx_vld_reg;
    assign CMD_ERR   = cmd_err_reg;
    assign RX_OVR    = rx_ovr_reg;

endmodule
